image_byte_loader: RTL and testbench
====================================

Name: image_byte_loader

Overview:
- Upstream feeder for the 900-bit image buffer. Accepts raw image bytes from the host receive path (SPI/UART byte strobe) into a small FIFO.
- Frames each image as exactly 113 bytes. Drives the buffer's edge-triggered write_request / write_ack handshake one byte at a time.
- Reports frame completion, receive overflow and handshake timeout to the top-level controller.

Parameters:
- FRAME_BYTES, 113, bytes per image frame; the last byte carries 4 valid LSBs.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- ACK_TIMEOUT, 16, cycles to wait for write_ack before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse: abort any frame in progress and begin a new one.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- write_ready  in  1  buffer can accept a byte.
- write_ack  in  1  buffer accepted the byte.
- clear_buffer  out  1  one-cycle pulse to reset the buffer.
- data_out  out  8  byte presented to the buffer.
- write_request  out  1  level request; the buffer samples its rising edge.
- frame_done  out  1  one-cycle pulse when byte FRAME_BYTES is acknowledged.
- busy  out  1  high in any state other than IDLE or DONE.
- overflow_err  out  1  sticky: rx_valid arrived while the FIFO was full.
- timeout_err  out  1  sticky: no write_ack within ACK_TIMEOUT cycles.
- byte_count  out  7  bytes acknowledged in the current frame, 0..113.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; byte_count 0.
- Reset is asynchronous and takes effect mid-frame with no further write_request.
- FIFO:
  - Writes on rx_valid in any non-IDLE state; rx_valid in IDLE or DONE is dropped silently.
  - When full, the incoming byte is dropped and overflow_err is set.
  - Simultaneous push and pop while full is permitted (no overflow).
  - Pointers wrap modulo FIFO_DEPTH.
  - The FIFO is flushed on frame_start.
- States: IDLE, CLEAR, FETCH, REQ, WAIT_ACK, GAP, DONE, ERR.
- Transitions:
  - Any state with frame_start=1 -> CLEAR. This has priority over every other event in the same cycle. It also clears byte_count, overflow_err and timeout_err, and flushes the FIFO.
  - CLEAR: clear_buffer=1 for exactly one cycle -> FETCH.
  - FETCH: if the FIFO is non-empty and write_ready=1, pop the head into the data_out register -> REQ. Otherwise stay.
  - REQ: write_request=1; ack timer loaded with 0 -> WAIT_ACK.
  - WAIT_ACK: hold write_request=1 and data_out stable.
    - On write_ack=1: byte_count+1 -> GAP.
    - If the timer reaches ACK_TIMEOUT without an ack: timeout_err=1 -> ERR.
  - GAP: write_request=0 for at least one cycle, guaranteeing a fresh rising edge for the next byte.
    - If byte_count==FRAME_BYTES -> DONE with frame_done=1 for one cycle.
    - Otherwise -> FETCH.
  - DONE: idle-equivalent; bytes are ignored until frame_start.
  - ERR: write_request=0; exits only on frame_start or rst.
- Latency: with the FIFO pre-loaded and a buffer that acks one cycle after the request edge, each byte takes 4 cycles: FETCH, REQ, WAIT_ACK, GAP.
- write_request never rises outside REQ and never falls before ack or timeout.
- byte_count saturates at FRAME_BYTES and is never incremented past it.
- Extra bytes received after byte FRAME_BYTES within the same frame are discarded when the frame enters DONE.
- Arithmetic: byte_count is 7-bit unsigned. The timer is $clog2(ACK_TIMEOUT+1) bits.

Test Plan:
- Nominal frame: frame_start, then 113 rx_valid bytes of value (i & 0xFF) spaced 5 cycles apart, with a model buffer acking 1 cycle after the edge.
  - Expect exactly 113 write_request rising edges and data_out sequence 0..112.
  - Expect frame_done pulse once, byte_count=113, and clear_buffer pulsed once.
- Back-to-back burst: 6 rx_valid on consecutive cycles with FIFO_DEPTH=4 and the buffer stalled (write_ready=0).
  - Expect overflow_err=1 after the 5th byte and FIFO holding bytes 1..4.
  - Release write_ready: bytes 1..4 are delivered in order.
- Ack timeout: buffer never asserts write_ack.
  - Expect write_request high for exactly 16 cycles, then timeout_err=1, state ERR, write_request=0.
- Abort mid-frame: frame_start at byte 50.
  - Expect clear_buffer pulse, byte_count=0, errors cleared.
  - The following 113 bytes complete normally with frame_done.
- Asynchronous reset asserted during WAIT_ACK: all outputs 0 immediately with no clock edge needed; after release the block sits in IDLE.
- Post-frame bytes: 120 bytes sent in one frame.
  - Expect exactly 113 acknowledged; bytes 114-120 produce no write_request.
  - overflow_err stays 0.

Source files
------------

// File: rtl/image_byte_loader.sv
// Receives host image bytes into a small FIFO and hands them to the image buffer
// one at a time over a level request / ack handshake, framing each image at FRAME_BYTES.
module image_byte_loader #(
   parameter int FRAME_BYTES = 113,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       write_ready,
   input  logic       write_ack,
   output logic       clear_buffer,
   output logic [7:0] data_out,
   output logic       write_request,
   output logic       frame_done,
   output logic       busy,
   output logic       overflow_err,
   output logic       timeout_err,
   output logic [6:0] byte_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, REQ, WAIT_ACK, GAP, DONE, ERR} state_t;
   state_t state;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   fill;
   logic [TW-1:0] timer;
   logic          last_byte, fifo_empty, fifo_full, accepting, flush, pop, push;

   assign last_byte  = (byte_count == 7'(FRAME_BYTES));
   assign fifo_empty = (fill == '0);
   assign fifo_full  = (fill == (AW+1)'(FIFO_DEPTH));
   assign accepting  = (state != IDLE) && (state != DONE);
   // Entering DONE flushes too, so trailing bytes of an over-long frame vanish.
   assign flush      = frame_start || ((state == GAP) && last_byte);
   assign pop        = !frame_start && (state == FETCH) && !fifo_empty && write_ready;
   assign push       = rx_valid && accepting && !flush && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         fill         <= '0;
         overflow_err <= 1'b0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         fill   <= '0;
         if (frame_start) overflow_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fill <= fill + (AW+1)'(1);
         else if (pop && !push) fill <= fill - (AW+1)'(1);
         if (rx_valid && accepting && fifo_full && !pop) overflow_err <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         clear_buffer  <= 1'b0;
         data_out      <= '0;
         write_request <= 1'b0;
         frame_done    <= 1'b0;
         busy          <= 1'b0;
         timeout_err   <= 1'b0;
         byte_count    <= '0;
         timer         <= '0;
      end else begin
         clear_buffer <= 1'b0;
         frame_done   <= 1'b0;
         if (frame_start) begin
            state         <= CLEAR;
            clear_buffer  <= 1'b1;
            write_request <= 1'b0;
            busy          <= 1'b1;
            timeout_err   <= 1'b0;
            byte_count    <= '0;
            timer         <= '0;
         end else begin
            case (state)
               CLEAR: state <= FETCH;
               FETCH: begin
                  if (pop) begin
                     data_out      <= mem[rd_ptr];
                     write_request <= 1'b1;
                     timer         <= '0;
                     state         <= REQ;
                  end
               end
               REQ: begin
                  timer <= timer + TW'(1);
                  state <= WAIT_ACK;
               end
               WAIT_ACK: begin
                  // timer counts cycles with write_request high, including REQ
                  if (write_ack) begin
                     write_request <= 1'b0;
                     if (!last_byte) byte_count <= byte_count + 7'd1;
                     state <= GAP;
                  end else if (timer >= TW'(ACK_TIMEOUT - 1)) begin
                     write_request <= 1'b0;
                     timeout_err   <= 1'b1;
                     state         <= ERR;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
               GAP: begin
                  if (last_byte) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                  end else begin
                     state <= FETCH;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_image_byte_loader.sv
// Bench for image_byte_loader: a transaction-level model (byte queue, counters, flags)
// is compared against the DUT every cycle, with directed and randomized frames.
module tb_image_byte_loader;
   localparam int FB = 113, DEPTH = 4, TMO = 16;

   logic       clk = 1'b0, rst = 1'b1, frame_start = 1'b0, rx_valid = 1'b0;
   logic       write_ready = 1'b1, write_ack = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       clear_buffer, write_request, frame_done, busy, overflow_err, timeout_err;
   logic [7:0] data_out;
   logic [6:0] byte_count;

   image_byte_loader #(.FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .write_ready(write_ready), .write_ack(write_ack),
      .clear_buffer(clear_buffer), .data_out(data_out), .write_request(write_request),
      .frame_done(frame_done), .busy(busy), .overflow_err(overflow_err),
      .timeout_err(timeout_err), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int vec = 0, errs = 0;
   task automatic chk(input string name, input int act, input int exp);
      vec++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Buffer model: acks ack_delay cycles after the request edge (0 = never), holds ack until request drops.
   int ack_delay = 1, wait_cnt = 0;
   bit req_seen = 0;
   always @(posedge clk) begin
      #1;
      if (rst || !write_request) begin
         req_seen  = 0;
         write_ack = 1'b0;
      end else if (!req_seen) begin
         req_seen = 1;
         wait_cnt = 0;
      end else begin
         wait_cnt++;
         if (ack_delay != 0 && wait_cnt >= ack_delay) write_ack = 1'b1;
      end
   end

   // Reference model, advanced once per cycle from the inputs the DUT sampled at the last edge.
   logic [7:0] q[$];
   logic [7:0] held = 8'h00, p_byte = 8'h00;
   bit   act = 0, done_pend = 0, exp_clr = 0, exp_done = 0, ovf = 0, tmo = 0, wr_prev = 0;
   bit   p_fs = 0, p_rv = 0, p_ack = 0, hs;
   int   cnt = 0, hi = 0, hi_len = 0, n_rise = 0, n_done = 0, n_clear = 0, cyc = 0;
   int   rise_cyc[$], rise_dat[$];

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         act = 0; done_pend = 0; exp_clr = 0; exp_done = 0; ovf = 0; tmo = 0; cnt = 0; hi = 0;
         chk("reset_outputs", int'({clear_buffer, write_request, frame_done, busy,
                                    overflow_err, timeout_err, data_out, byte_count}), 0);
         wr_prev = 0;
      end else begin
         hs = wr_prev && p_ack;
         if (p_fs) begin
            q.delete();
            cnt = 0; ovf = 0; tmo = 0; act = 1; done_pend = 0; exp_clr = 1; exp_done = 0;
         end else begin
            exp_clr = 0; exp_done = 0;
            if (done_pend) begin
               done_pend = 0; act = 0; exp_done = 1;
               q.delete();
            end else begin
               if (write_request && !wr_prev) begin
                  chk("req_has_byte", int'(q.size() > 0), 1);
                  if (q.size() > 0) begin
                     held = q.pop_front();
                     chk("data_out", int'(data_out), int'(held));
                  end
               end
               if (p_rv && act) begin
                  if (q.size() == DEPTH) ovf = 1;
                  else q.push_back(p_byte);
               end
               if (hs) begin
                  if (cnt < FB) cnt++;
                  if (cnt == FB) done_pend = 1;
               end
            end
            if (write_request && wr_prev) chk("data_hold", int'(data_out), int'(held));
            if (hs) chk("req_drop_after_ack", int'(write_request), 0);
            if (!write_request && wr_prev && !hs) begin
               hi_len = hi;
               chk("req_high_cycles", hi, TMO);
               tmo = 1;
            end
         end
         if (write_request) hi++; else hi = 0;
         if (hi > TMO) chk("req_high_limit", hi, TMO);
         chk("byte_count", int'(byte_count), cnt);
         chk("overflow_err", int'(overflow_err), int'(ovf));
         chk("timeout_err", int'(timeout_err), int'(tmo));
         chk("busy", int'(busy), int'(act));
         chk("clear_buffer", int'(clear_buffer), int'(exp_clr));
         chk("frame_done", int'(frame_done), int'(exp_done));
         if (write_request && !wr_prev) begin
            n_rise++;
            rise_cyc.push_back(cyc);
            rise_dat.push_back(int'(data_out));
         end
         if (frame_done) n_done++;
         if (clear_buffer) n_clear++;
         wr_prev = write_request;
      end
      p_fs = frame_start; p_rv = rx_valid; p_byte = rx_byte; p_ack = write_ack;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      if (gap > 1) tick(gap - 1);
   endtask

   task automatic wait_done(input int base, input int limit, input string name);
      int k = 0;
      while (n_done == base && k < limit) begin
         tick(1);
         k++;
      end
      chk(name, n_done, base + 1);
   endtask

   int r0, d0, c0, k;

   initial begin
      tick(3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_write_request", int'(write_request), 0);
      chk("rst_byte_count", int'(byte_count), 0);
      rst = 1'b0;
      tick(2);

      // nominal frame, data i, 5-cycle spacing, ack one cycle after the edge
      r0 = n_rise; d0 = n_done; c0 = n_clear;
      rise_dat.delete();
      pulse_start();
      chk("nominal_clear_pulse", int'(clear_buffer), 1);
      for (int i = 0; i < FB; i++) send(8'(i), 5);
      wait_done(d0, 50, "nominal_frame_done");
      tick(3);
      chk("nominal_rises", n_rise - r0, FB);
      chk("nominal_count", int'(byte_count), 113);
      chk("nominal_clear_count", n_clear - c0, 1);
      chk("nominal_done_count", n_done - d0, 1);
      chk("nominal_first_data", rise_dat[0], 0);
      chk("nominal_last_data", rise_dat[rise_dat.size()-1], 112);

      // back-to-back burst into a stalled buffer
      pulse_start();
      write_ready = 1'b0;
      tick(2);
      r0 = n_rise;
      rise_dat.delete(); rise_cyc.delete();
      for (int i = 1; i <= 6; i++) begin
         rx_byte  = 8'(i);
         rx_valid = 1'b1;
         tick(1);
         if (i == 4) chk("burst_no_ovf_at_4", int'(overflow_err), 0);
         if (i == 5) chk("burst_ovf_at_5", int'(overflow_err), 1);
      end
      rx_valid = 1'b0;
      chk("burst_no_req_stalled", n_rise - r0, 0);
      write_ready = 1'b1;
      tick(20);
      chk("burst_delivered", n_rise - r0, 4);
      for (int i = 0; i < 4 && i < rise_dat.size(); i++) chk("burst_data", rise_dat[i], i + 1);
      for (int i = 1; i < 4 && i < rise_cyc.size(); i++)
         chk("burst_cycles_per_byte", rise_cyc[i] - rise_cyc[i-1], 4);
      chk("burst_count", int'(byte_count), 4);

      // ack timeout
      pulse_start();
      chk("start_clears_ovf", int'(overflow_err), 0);
      ack_delay = 0;
      send(8'hA5, 1);
      k = 0;
      while (!timeout_err && k < 60) begin tick(1); k++; end
      chk("timeout_seen", int'(timeout_err), 1);
      tick(2);
      chk("timeout_req_len", hi_len, 16);
      chk("timeout_req_low", int'(write_request), 0);
      chk("timeout_err_busy", int'(busy), 1);

      // abort at byte 50, then a full randomized frame
      pulse_start();
      chk("start_clears_tmo", int'(timeout_err), 0);
      ack_delay = 1;
      for (int i = 0; i < 50; i++) send(8'(i + 50), 5);
      tick(2);
      c0 = n_clear;
      pulse_start();
      chk("abort_clear_pulse", int'(clear_buffer), 1);
      chk("abort_count", int'(byte_count), 0);
      d0 = n_done;
      for (int i = 0; i < FB; i++) begin
         ack_delay   = $urandom_range(1, 3);
         write_ready = ($urandom_range(0, 3) != 0);
         send(8'($urandom), $urandom_range(8, 10));
      end
      write_ready = 1'b1;
      ack_delay   = 1;
      wait_done(d0, 100, "abort_frame_done");
      tick(2);
      chk("abort_final_count", int'(byte_count), 113);
      chk("abort_clear_count", n_clear - c0, 1);

      // asynchronous reset while waiting for ack
      pulse_start();
      send(8'h01, 5);
      send(8'h02, 5);
      ack_delay = 0;
      send(8'h03, 1);
      k = 0;
      while (!write_request && k < 20) begin tick(1); k++; end
      chk("async_req_up", int'(write_request), 1);
      tick(2);
      #2 rst = 1'b1;
      #1;
      chk("async_req", int'(write_request), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_count", int'(byte_count), 0);
      chk("async_data", int'(data_out), 0);
      tick(2);
      rst = 1'b0;
      ack_delay = 1;
      tick(3);
      r0 = n_rise;
      send(8'h77, 6);
      chk("idle_busy", int'(busy), 0);
      chk("idle_drop", n_rise - r0, 0);

      // 120 bytes in one frame: only 113 go out
      pulse_start();
      r0 = n_rise; d0 = n_done;
      for (int i = 0; i < 120; i++) send(8'(i + 7), 5);
      wait_done(d0, 50, "post_frame_done");
      tick(10);
      chk("post_rises", n_rise - r0, FB);
      chk("post_count", int'(byte_count), 113);
      chk("post_ovf", int'(overflow_err), 0);
      chk("post_done_once", n_done - d0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end
endmodule
